// File: rtl/router_east_sched.sv
// router_east_sched: programmable routing-mode schedule with per-entry transfer
// counts and a round-robin source grant for the east-edge mesh router.
module router_east_sched #(
  parameter int         DATA_WIDTH  = 16,
  parameter int         NUM_ENTRIES = 8,
  parameter int         CNT_WIDTH   = 8,
  parameter logic [3:0] IDLE_MODE   = 4'd4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cfg_we,
  input  logic [$clog2(NUM_ENTRIES)-1:0] cfg_addr,
  input  logic [3:0]                     cfg_mode,
  input  logic [CNT_WIDTH-1:0]           cfg_count,
  input  logic [$clog2(NUM_ENTRIES):0]   cfg_len,
  input  logic                           start,
  input  logic [3:0]                     req_i,
  output logic [3:0]                     gnt_o,
  output logic                           xfer_o,
  output logic [3:0]                     router_mode_o,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           cfg_err_o
);
  localparam int            AW       = $clog2(NUM_ENTRIES);
  localparam int            LW       = AW + 1;
  localparam logic [LW-1:0] LEN_MAX  = LW'(NUM_ENTRIES);
  localparam logic [3:0]    MODE_MAX = 4'd10;

  if ((NUM_ENTRIES < 2) || ((NUM_ENTRIES & (NUM_ENTRIES - 1)) != 0) || (DATA_WIDTH < 1))
  begin : g_param_check
    $error("router_east_sched: NUM_ENTRIES must be a power of two >= 2");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e               state_r, state_nxt_s;
  logic [3:0]           mode_tbl_r  [NUM_ENTRIES];
  logic [CNT_WIDTH-1:0] count_tbl_r [NUM_ENTRIES];
  logic [LW-1:0]        len_r, len_nxt_s;
  logic [AW-1:0]        idx_r, idx_nxt_s, idx_inc_s;
  logic [CNT_WIDTH-1:0] remaining_r, remaining_nxt_s, rem_after_s;
  logic [1:0]           rr_ptr_r, rr_ptr_nxt_s;
  logic [3:0]           mode_out_r, mode_out_nxt_s;
  logic                 cfg_err_r, cfg_err_nxt_s;
  logic                 busy_r, busy_nxt_s;
  logic                 done_r, done_nxt_s;
  logic                 wr_ok_s, wr_bad_s, run_ok_s, grant_s, last_entry_s;
  logic [3:0]           first_mode_s, gnt_s;
  logic [CNT_WIDTH-1:0] first_count_s;

  assign wr_ok_s   = cfg_we && (state_r == S_IDLE) && (cfg_mode <= MODE_MAX);
  assign wr_bad_s  = cfg_we && !wr_ok_s;
  assign run_ok_s  = (state_r == S_RUN) && (remaining_r != {CNT_WIDTH{1'b0}});
  assign idx_inc_s = idx_r + {{(AW-1){1'b0}}, 1'b1};
  assign last_entry_s = ({1'b0, idx_r} == (len_r - {{AW{1'b0}}, 1'b1}));

  // A write in the same cycle as start must be visible to the first entry load.
  assign first_mode_s  = (wr_ok_s && (cfg_addr == {AW{1'b0}})) ? cfg_mode  : mode_tbl_r[0];
  assign first_count_s = (wr_ok_s && (cfg_addr == {AW{1'b0}})) ? cfg_count : count_tbl_r[0];

  // Schedule table: cleared on reset, written only by legal idle-state writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        mode_tbl_r[i]  <= 4'd0;
        count_tbl_r[i] <= {CNT_WIDTH{1'b0}};
      end
    end else if (wr_ok_s) begin
      mode_tbl_r[cfg_addr]  <= cfg_mode;
      count_tbl_r[cfg_addr] <= cfg_count;
    end else begin
      mode_tbl_r  <= mode_tbl_r;
      count_tbl_r <= count_tbl_r;
    end
  end

  // Round-robin pick starting at rr_ptr, only while the entry has transfers left.
  always_comb begin
    logic [1:0] pos;
    logic       found;
    logic       take;
    gnt_s        = 4'b0000;
    rr_ptr_nxt_s = rr_ptr_r;
    pos          = rr_ptr_r;
    found        = 1'b0;
    take         = 1'b0;
    for (int k = 0; k < 4; k++) begin
      pos          = rr_ptr_r + k[1:0];
      take         = run_ok_s & ~found & req_i[pos];
      gnt_s[pos]   = take;
      rr_ptr_nxt_s = take ? (pos + 2'd1) : rr_ptr_nxt_s;
      found        = found | req_i[pos];
    end
  end

  assign grant_s = |gnt_s;

  // Schedule sequencing: entry loading, transfer accounting and state transitions.
  always_comb begin
    state_nxt_s     = state_r;
    len_nxt_s       = len_r;
    idx_nxt_s       = idx_r;
    remaining_nxt_s = remaining_r;
    mode_out_nxt_s  = mode_out_r;
    busy_nxt_s      = 1'b0;
    done_nxt_s      = 1'b0;
    cfg_err_nxt_s   = cfg_err_r | wr_bad_s;
    rem_after_s     = remaining_r - {{(CNT_WIDTH-1){1'b0}}, grant_s};
    case (state_r)
      S_IDLE: begin
        if (start) begin
          cfg_err_nxt_s = 1'b0;
          idx_nxt_s     = {AW{1'b0}};
          len_nxt_s     = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
          if (cfg_len == {LW{1'b0}}) begin
            state_nxt_s    = S_DONE;
            done_nxt_s     = 1'b1;
            mode_out_nxt_s = IDLE_MODE;
          end else begin
            state_nxt_s     = S_RUN;
            busy_nxt_s      = 1'b1;
            mode_out_nxt_s  = first_mode_s;
            remaining_nxt_s = first_count_s;
          end
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_RUN: begin
        // Entry ends when nothing is left, including entries loaded with count 0.
        if (rem_after_s == {CNT_WIDTH{1'b0}}) begin
          remaining_nxt_s = {CNT_WIDTH{1'b0}};
          if (last_entry_s) begin
            state_nxt_s    = S_DONE;
            done_nxt_s     = 1'b1;
            mode_out_nxt_s = IDLE_MODE;
          end else begin
            state_nxt_s     = S_RUN;
            busy_nxt_s      = 1'b1;
            idx_nxt_s       = idx_inc_s;
            mode_out_nxt_s  = mode_tbl_r[idx_inc_s];
            remaining_nxt_s = count_tbl_r[idx_inc_s];
          end
        end else begin
          state_nxt_s     = S_RUN;
          busy_nxt_s      = 1'b1;
          remaining_nxt_s = rem_after_s;
        end
      end
      S_DONE: begin
        state_nxt_s    = S_IDLE;
        mode_out_nxt_s = IDLE_MODE;
      end
      default: begin
        state_nxt_s    = S_IDLE;
        mode_out_nxt_s = IDLE_MODE;
      end
    endcase
  end

  // Control state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      len_r       <= {LW{1'b0}};
      idx_r       <= {AW{1'b0}};
      remaining_r <= {CNT_WIDTH{1'b0}};
      rr_ptr_r    <= 2'd0;
      mode_out_r  <= IDLE_MODE;
      cfg_err_r   <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      len_r       <= len_nxt_s;
      idx_r       <= idx_nxt_s;
      remaining_r <= remaining_nxt_s;
      rr_ptr_r    <= rr_ptr_nxt_s;
      mode_out_r  <= mode_out_nxt_s;
      cfg_err_r   <= cfg_err_nxt_s;
      busy_r      <= busy_nxt_s;
      done_r      <= done_nxt_s;
    end
  end

  assign gnt_o         = gnt_s;
  assign xfer_o        = grant_s;
  assign router_mode_o = mode_out_r;
  assign busy_o        = busy_r;
  assign done_o        = done_r;
  assign cfg_err_o     = cfg_err_r;

endmodule

// File: tb/tb_router_east_sched.sv
// Bench for router_east_sched: directed vector table, hand-written corner
// sequences, then random traffic against a queue-based schedule model.
`timescale 1ns/1ps
module tb_router_east_sched;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_we = 1'b0;
  logic [2:0] cfg_addr = 3'd0;
  logic [3:0] cfg_mode = 4'd0;
  logic [7:0] cfg_count = 8'd0;
  logic [3:0] cfg_len = 4'd0;
  logic       start = 1'b0;
  logic [3:0] req_i = 4'd0;
  logic [3:0] gnt_o, router_mode_o;
  logic       xfer_o, busy_o, done_o, cfg_err_o;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  router_east_sched dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_mode(cfg_mode),
    .cfg_count(cfg_count), .cfg_len(cfg_len), .start(start), .req_i(req_i),
    .gnt_o(gnt_o), .xfer_o(xfer_o), .router_mode_o(router_mode_o),
    .busy_o(busy_o), .done_o(done_o), .cfg_err_o(cfg_err_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic chk_out(input string name, input logic [3:0] eg, input logic [3:0] em,
                         input logic eb, input logic ed);
    chk({name, ".gnt"},  32'(gnt_o), 32'(eg));
    chk({name, ".xfer"}, 32'(xfer_o), 32'(|eg));
    chk({name, ".mode"}, 32'(router_mode_o), 32'(em));
    chk({name, ".busy"}, 32'(busy_o), 32'(eb));
    chk({name, ".done"}, 32'(done_o), 32'(ed));
  endtask

  // Drive one cycle of inputs away from the rising edge; outputs are then sampled.
  task automatic step(input logic r, input logic we, input logic [2:0] a, input logic [3:0] m,
                      input logic [7:0] c, input logic [3:0] l, input logic s, input logic [3:0] q);
    @(negedge clk);
    rst = r; cfg_we = we; cfg_addr = a; cfg_mode = m; cfg_count = c;
    cfg_len = l; start = s; req_i = q;
    #1;
  endtask

  task automatic idle(input logic [3:0] q);
    step(1'b0, 1'b0, 3'd0, 4'd0, 8'd0, 4'd0, 1'b0, q);
  endtask

  typedef struct {
    logic       we;
    logic [2:0] addr;
    logic [3:0] mode;
    logic [7:0] count;
    logic [3:0] len;
    logic       start;
    logic [3:0] req;
    logic [3:0] e_gnt;
    logic [3:0] e_mode;
    logic       e_busy;
    logic       e_done;
  } vec_t;
  vec_t vecs[$];

  task automatic push(input logic we, input logic [2:0] a, input logic [3:0] m, input logic [7:0] c,
                      input logic [3:0] l, input logic s, input logic [3:0] q,
                      input logic [3:0] eg, input logic [3:0] em, input logic eb, input logic ed);
    vec_t v;
    v.we = we; v.addr = a; v.mode = m; v.count = c; v.len = l; v.start = s; v.req = q;
    v.e_gnt = eg; v.e_mode = em; v.e_busy = eb; v.e_done = ed;
    vecs.push_back(v);
  endtask

  // Reference model: the run is a queue of (mode, count) entries consumed in order.
  int         m_phase;  // 0 idle, 1 running, 2 done
  int         m_left, m_rr;
  bit         m_err;
  logic [3:0] m_tmode[8];
  int         m_tcnt[8];
  int         q_mode[$];
  int         q_cnt[$];

  task automatic model_reset();
    m_phase = 0; m_left = 0; m_rr = 0; m_err = 1'b0;
    q_mode.delete(); q_cnt.delete();
    for (int j = 0; j < 8; j++) begin m_tmode[j] = 4'd0; m_tcnt[j] = 0; end
  endtask

  function automatic logic [3:0] m_grant(input logic [3:0] q);
    logic [3:0] g = 4'b0000;
    if (m_phase == 1 && m_left > 0) begin
      for (int k = 0; k < 4; k++) begin
        int p = (m_rr + k) % 4;
        if (q[p]) begin g[p] = 1'b1; return g; end
      end
    end
    return g;
  endfunction

  function automatic logic [3:0] m_mode_out();
    return (m_phase == 1) ? 4'(q_mode[0]) : 4'd4;
  endfunction

  task automatic model_update(input logic r, input logic we, input logic [2:0] a, input logic [3:0] m,
                              input logic [7:0] c, input logic [3:0] l, input logic s, input logic [3:0] q);
    logic [3:0] g;
    if (r) begin model_reset(); return; end
    g = m_grant(q);
    if (we) begin
      if (m_phase == 0 && m <= 4'd10) begin m_tmode[a] = m; m_tcnt[a] = int'(c); end
      else m_err = 1'b1;
    end
    case (m_phase)
      0: if (s) begin
        int n;
        m_err = 1'b0;
        n = (int'(l) > 8) ? 8 : int'(l);
        q_mode.delete(); q_cnt.delete();
        for (int j = 0; j < n; j++) begin q_mode.push_back(int'(m_tmode[j])); q_cnt.push_back(m_tcnt[j]); end
        if (n == 0) m_phase = 2;
        else begin m_phase = 1; m_left = q_cnt[0]; end
      end
      1: begin
        if (g != 4'b0000) begin
          m_left--;
          for (int k = 0; k < 4; k++) if (g[k]) m_rr = (k + 1) % 4;
        end
        if (m_left == 0) begin
          void'(q_mode.pop_front()); void'(q_cnt.pop_front());
          if (q_mode.size() == 0) m_phase = 2;
          else m_left = q_cnt[0];
        end
      end
      default: m_phase = 0;
    endcase
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [3:0] rg, rm;
    logic [11:0] act, exp;
    logic r, we, s;
    logic [2:0] a;
    logic [3:0] m, l, q;
    logic [7:0] c;

    // Round-robin: mode 0, count 8, all requesting.
    push(1'b1, 3'd0, 4'd0, 8'd8, 4'd0, 1'b0, 4'hF, 4'h0, 4'd4, 1'b0, 1'b0);
    push(1'b0, 3'd0, 4'd0, 8'd0, 4'd1, 1'b1, 4'hF, 4'h0, 4'd4, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++)
      push(1'b0, 3'd0, 4'd0, 8'd0, 4'd0, 1'b0, 4'hF, 4'(1 << (i % 4)), 4'd0, 1'b1, 1'b0);
    push(1'b0, 3'd0, 4'd0, 8'd0, 4'd0, 1'b0, 4'hF, 4'h0, 4'd4, 1'b0, 1'b1);
    push(1'b0, 3'd0, 4'd0, 8'd0, 4'd0, 1'b0, 4'h0, 4'h0, 4'd4, 1'b0, 1'b0);
    // Single entry: mode 1, count 3, north only.
    push(1'b1, 3'd0, 4'd1, 8'd3, 4'd0, 1'b0, 4'h0, 4'h0, 4'd4, 1'b0, 1'b0);
    push(1'b0, 3'd0, 4'd0, 8'd0, 4'd1, 1'b1, 4'h1, 4'h0, 4'd4, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      push(1'b0, 3'd0, 4'd0, 8'd0, 4'd0, 1'b0, 4'h1, 4'h1, 4'd1, 1'b1, 1'b0);
    push(1'b0, 3'd0, 4'd0, 8'd0, 4'd0, 1'b0, 4'h1, 4'h0, 4'd4, 1'b0, 1'b1);
    push(1'b0, 3'd0, 4'd0, 8'd0, 4'd0, 1'b0, 4'h0, 4'h0, 4'd4, 1'b0, 1'b0);
    // Multi-entry with a count-0 gap: (5,2) (7,0) (9,1), west only.
    push(1'b1, 3'd0, 4'd5, 8'd2, 4'd0, 1'b0, 4'h0, 4'h0, 4'd4, 1'b0, 1'b0);
    push(1'b1, 3'd1, 4'd7, 8'd0, 4'd0, 1'b0, 4'h0, 4'h0, 4'd4, 1'b0, 1'b0);
    push(1'b1, 3'd2, 4'd9, 8'd1, 4'd0, 1'b0, 4'h0, 4'h0, 4'd4, 1'b0, 1'b0);
    push(1'b0, 3'd0, 4'd0, 8'd0, 4'd3, 1'b1, 4'h4, 4'h0, 4'd4, 1'b0, 1'b0);
    push(1'b0, 3'd0, 4'd0, 8'd0, 4'd0, 1'b0, 4'h4, 4'h4, 4'd5, 1'b1, 1'b0);
    push(1'b0, 3'd0, 4'd0, 8'd0, 4'd0, 1'b0, 4'h4, 4'h4, 4'd5, 1'b1, 1'b0);
    push(1'b0, 3'd0, 4'd0, 8'd0, 4'd0, 1'b0, 4'h4, 4'h0, 4'd7, 1'b1, 1'b0);
    push(1'b0, 3'd0, 4'd0, 8'd0, 4'd0, 1'b0, 4'h4, 4'h4, 4'd9, 1'b1, 1'b0);
    push(1'b0, 3'd0, 4'd0, 8'd0, 4'd0, 1'b0, 4'h4, 4'h0, 4'd4, 1'b0, 1'b1);
    push(1'b0, 3'd0, 4'd0, 8'd0, 4'd0, 1'b0, 4'h0, 4'h0, 4'd4, 1'b0, 1'b0);
    // Length 0: straight to DONE.
    push(1'b0, 3'd0, 4'd0, 8'd0, 4'd0, 1'b1, 4'hF, 4'h0, 4'd4, 1'b0, 1'b0);
    push(1'b0, 3'd0, 4'd0, 8'd0, 4'd0, 1'b0, 4'hF, 4'h0, 4'd4, 1'b0, 1'b1);
    push(1'b0, 3'd0, 4'd0, 8'd0, 4'd0, 1'b0, 4'h0, 4'h0, 4'd4, 1'b0, 1'b0);
    // Length 15 clamps to 8 entries: modes 1..8, one transfer each.
    for (int i = 0; i < 8; i++)
      push(1'b1, 3'(i), 4'(i + 1), 8'd1, 4'd0, 1'b0, 4'h0, 4'h0, 4'd4, 1'b0, 1'b0);
    push(1'b0, 3'd0, 4'd0, 8'd0, 4'd15, 1'b1, 4'h1, 4'h0, 4'd4, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++)
      push(1'b0, 3'd0, 4'd0, 8'd0, 4'd0, 1'b0, 4'h1, 4'h1, 4'(i + 1), 1'b1, 1'b0);
    push(1'b0, 3'd0, 4'd0, 8'd0, 4'd0, 1'b0, 4'h1, 4'h0, 4'd4, 1'b0, 1'b1);
    push(1'b0, 3'd0, 4'd0, 8'd0, 4'd0, 1'b0, 4'h0, 4'h0, 4'd4, 1'b0, 1'b0);

    // Reset state.
    step(1'b1, 1'b0, 3'd0, 4'd0, 8'd0, 4'd0, 1'b0, 4'hF);
    step(1'b1, 1'b0, 3'd0, 4'd0, 8'd0, 4'd0, 1'b0, 4'hF);
    idle(4'hF);
    chk_out("reset", 4'h0, 4'd4, 1'b0, 1'b0);
    chk("reset.err", 32'(cfg_err_o), 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(1'b0, vecs[i].we, vecs[i].addr, vecs[i].mode, vecs[i].count, vecs[i].len,
           vecs[i].start, vecs[i].req);
      chk_out($sformatf("vec%0d", i), vecs[i].e_gnt, vecs[i].e_mode, vecs[i].e_busy, vecs[i].e_done);
      chk($sformatf("vec%0d.err", i), 32'(cfg_err_o), 32'd0);
    end

    // Illegal config: entry 0 holds (1,1); a bad mode and a RUN-time write must both drop.
    step(1'b0, 1'b1, 3'd0, 4'd12, 8'd9, 4'd0, 1'b0, 4'h0);
    idle(4'h0);
    chk("bad_mode.err", 32'(cfg_err_o), 32'd1);
    step(1'b0, 1'b0, 3'd0, 4'd0, 8'd0, 4'd1, 1'b1, 4'h0);
    idle(4'h0);
    chk_out("ill_start", 4'h0, 4'd1, 1'b1, 1'b0);
    chk("ill_start.err", 32'(cfg_err_o), 32'd0);
    step(1'b0, 1'b1, 3'd0, 4'd3, 8'd5, 4'd0, 1'b0, 4'h0);
    idle(4'h1);
    chk_out("run_write", 4'h1, 4'd1, 1'b1, 1'b0);
    chk("run_write.err", 32'(cfg_err_o), 32'd1);
    idle(4'h0);
    chk_out("ill_done", 4'h0, 4'd4, 1'b0, 1'b1);
    step(1'b0, 1'b0, 3'd0, 4'd0, 8'd0, 4'd1, 1'b1, 4'h1);
    idle(4'h1);
    chk_out("ill_rerun", 4'h1, 4'd1, 1'b1, 1'b0);
    chk("ill_rerun.err", 32'(cfg_err_o), 32'd0);
    idle(4'h0);
    chk_out("ill_rerun_done", 4'h0, 4'd4, 1'b0, 1'b1);

    // Reset mid-RUN clears the table and the in-flight schedule.
    step(1'b0, 1'b1, 3'd0, 4'd2, 8'd50, 4'd0, 1'b0, 4'hF);
    step(1'b0, 1'b0, 3'd0, 4'd0, 8'd0, 4'd1, 1'b1, 4'hF);
    idle(4'hF);
    chk_out("mid_run", 4'h2, 4'd2, 1'b1, 1'b0);
    idle(4'hF);
    step(1'b1, 1'b0, 3'd0, 4'd0, 8'd0, 4'd0, 1'b0, 4'hF);
    idle(4'hF);
    chk_out("mid_rst", 4'h0, 4'd4, 1'b0, 1'b0);
    chk("mid_rst.err", 32'(cfg_err_o), 32'd0);
    step(1'b0, 1'b0, 3'd0, 4'd0, 8'd0, 4'd1, 1'b1, 4'hF);
    idle(4'hF);
    chk_out("cleared_run", 4'h0, 4'd0, 1'b1, 1'b0);
    idle(4'hF);
    chk_out("cleared_done", 4'h0, 4'd4, 1'b0, 1'b1);

    // Random traffic against the model.
    step(1'b1, 1'b0, 3'd0, 4'd0, 8'd0, 4'd0, 1'b0, 4'h0);
    model_reset();
    for (int i = 0; i < 800; i++) begin
      r  = ($urandom_range(0, 199) == 0);
      we = ($urandom_range(0, 3) == 0);
      a  = 3'($urandom_range(0, 7));
      m  = 4'($urandom_range(0, 12));
      c  = 8'($urandom_range(0, 4));
      l  = 4'($urandom_range(0, 15));
      s  = ($urandom_range(0, 5) == 0);
      q  = 4'($urandom_range(0, 15));
      step(r, we, a, m, c, l, s, q);
      rg  = m_grant(q);
      rm  = m_mode_out();
      exp = {rg, |rg, rm, (m_phase == 1), (m_phase == 2), m_err};
      act = {gnt_o, xfer_o, router_mode_o, busy_o, done_o, cfg_err_o};
      chk($sformatf("rand%0d", i), 32'(act), 32'(exp));
      model_update(r, we, a, m, c, l, s, q);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
